seq_datapath: RTL and testbench
===============================

# seq_datapath

Parametrised, self-sequencing datapath. It has a register file, A/B operand registers, a B-path shifter, an ALU, a result register C and a 3-bit status register. A built-in FSM accepts one command per valid/ready handshake and steps it through operand read, execute and write-back. The top-level controller issues commands instead of driving loada/loadb/loadc/write cycle by cycle.

## Interface
Parameters:
- WIDTH, 16, datapath width in bits (≥4)
- NREGS, 8, register-file depth (power of 2, ≥2); RW = clog2(NREGS) is the register-index width

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  reset; asynchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_op  in  3  000 MOVI, 001 MOV, 010 ADD, 011 CMP, 100 AND, 101 MVN, 110/111 reserved (NOP)
- cmd_shift  in  2  shift applied to the Rm operand: 00 none, 01 lsl1, 10 lsr1, 11 asr1 (MSB replicated)
- cmd_rd, cmd_rn, cmd_rm  in  RW each  destination and source register indices
- cmd_imm  in  WIDTH  immediate for MOVI; not shifted
- done  out  1  one-cycle pulse: command complete
- result  out  WIDTH  C register contents
- status  out  3  {N, V, Z}
- dbg_addr  in  RW  debug read index
- dbg_data  out  WIDTH  combinational R[dbg_addr]

## Operation
- FSM states: IDLE, RDA, RDB, EXEC, WB.
- cmd_ready = 1 only in IDLE with reset_n high.
- Acceptance happens on a rising edge with cmd_valid & cmd_ready. All cmd_* fields are captured internally at acceptance and may change afterwards.
- Transitions out of IDLE on acceptance:
  - ADD/CMP/AND: go to RDA.
  - MOV/MVN: go to RDB (A unused; Ain = 0).
  - MOVI: go to EXEC.
  - NOP: go to WB.
- Fixed sequence after that: RDA→RDB→EXEC→WB→IDLE.
- RDA: A <= R[rn].
- RDB: B <= R[rm].
- EXEC: C <= ALU output and status updates. ALU ops:
  - MOVI: imm
  - MOV: sh(B)
  - ADD: A + sh(B)
  - CMP: A − sh(B)
  - AND: A & sh(B)
  - MVN: ~sh(B)
- Arithmetic is modulo 2^WIDTH.
- Status flags:
  - Z = (ALU out == 0).
  - N = ALU out[WIDTH-1].
  - V = signed overflow for ADD/CMP; 0 for all other ops.
- WB: done = 1 (Moore output).
  - R[rd] <= C on the exiting edge for every op except CMP and NOP.
  - CMP and NOP leave the registers unchanged. NOP also leaves C and status unchanged.
- rd may equal rn/rm. Sources are read before WB, so the old value is used.
- dbg_data reflects a write from the edge after WB onward.

## Timing
- Reset (reset_n low, asynchronous):
  - all R[i], A, B, C = 0; status = 000
  - state = IDLE; done = 0; cmd_ready = 0 while held low, 1 from the first cycle after release
- Reset mid-operation aborts the command: no write-back, no done.
- Latency is measured from the acceptance edge E0 to the done cycle, with the register write on the edge ending done:
  - ADD/CMP/AND: done during the cycle after E3; write at E4.
  - MOV/MVN: done after E2; write at E3.
  - MOVI: done after E1; write at E2.
  - NOP: done after E0; back to IDLE at E1.
- Earliest next acceptance is the edge after returning to IDLE (5-cycle issue interval for three-operand ops).
- cmd_valid held high while busy has no effect. Exactly one command is accepted per IDLE visit.
- result and status are stable from the EXEC edge until the next command's EXEC edge.

## Test plan
- **Reset:** pulse reset_n low mid-cycle (async) → dbg_data = 0 for all indices, status = 000, result = 0, done = 0, cmd_ready = 0 during reset and 1 after release.
- **ADD sequence (WIDTH=16):** MOVI R1 = 0x0007; MOVI R2 = 0x0002; ADD R3 = R1 + (R2 lsl1) → R3 = 0x000B, status = 000. done high exactly one cycle, 3 edges after the ADD acceptance edge. cmd_ready low from RDA through WB.
- **CMP overflow:** MOVI R4 = 0x7FFF, R5 = 0xFFFF; CMP R4, R5 → result = 0x8000, status N = 1, V = 1, Z = 0; R4, R5 and R0 unchanged.
- **Shift/logic:** MOVI R6 = 0x8000; MVN R7, R6 asr1 → R7 = 0x3FFF, status 000. Then AND R0 = R7 & R0 → R0 = 0, Z = 1.
- **Handshake/NOP:**
  - Hold cmd_valid high with changing fields for 10 cycles → only commands at IDLE edges are accepted.
  - op 111 → done one cycle after acceptance; result, status and registers unchanged.
  - ADD R1 = R1 + R1 with R1 = 3 → R1 = 6.
- **Reset mid-op and parametrisation:** assert reset_n during EXEC of ADD R3 → R3 = 0, no done. Rerun the ADD sequence with WIDTH=8, NREGS=4 → 0x0B; 0x7F − 0xFF gives N = 1, V = 1.

Source files
------------

// File: rtl/seq_datapath.sv
// seq_datapath: self-sequencing datapath. It contains a register file, the A/B
// operand registers, a shifter on the B path, an ALU, a result register C and
// an {N,V,Z} status register. A small FSM accepts one command per valid/ready
// handshake and steps it through operand read, execute and write-back.
//
// Ports
//   clk, reset_n           rising-edge clock, asynchronous active-low reset
//   cmd_valid / cmd_ready  command handshake (ready only while IDLE)
//   cmd_op                 000 MOVI, 001 MOV, 010 ADD, 011 CMP, 100 AND,
//                          101 MVN, 11x NOP
//   cmd_shift              Rm shift: 00 none, 01 lsl1, 10 lsr1, 11 asr1
//   cmd_rd/rn/rm, cmd_imm  register indices and MOVI immediate
//   done                   one-cycle pulse while in write-back
//   result, status         C register and {N,V,Z}
//   dbg_addr / dbg_data    combinational register-file read port
module seq_datapath #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  localparam int RW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [1:0]       cmd_shift,
  input  logic [RW-1:0]    cmd_rd,
  input  logic [RW-1:0]    cmd_rn,
  input  logic [RW-1:0]    cmd_rm,
  input  logic [WIDTH-1:0] cmd_imm,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       status,
  input  logic [RW-1:0]    dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  localparam logic [2:0] OP_MOVI = 3'b000;
  localparam logic [2:0] OP_MOV  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_CMP  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_MVN  = 3'b101;

  typedef enum logic [2:0] {S_IDLE, S_RDA, S_RDB, S_EXEC, S_WB} state_t;

  state_t state_reg, state_next;

  logic [2:0]       op_reg;
  logic [1:0]       shift_reg;
  logic [RW-1:0]    rd_reg, rn_reg, rm_reg;
  logic [WIDTH-1:0] imm_reg;
  logic [WIDTH-1:0] a_reg, b_reg, c_reg;
  logic [2:0]       status_reg;
  logic [WIDTH-1:0] regs [NREGS];

  logic             accept;
  logic [WIDTH-1:0] b_shifted, a_in, sum, diff, alu_out;
  logic             alu_v;
  logic             write_en;

  assign accept = cmd_valid & cmd_ready;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= S_IDLE;
    else          state_reg <= state_next;
  end

  // Next-state logic: the entry point depends on which operands the op needs,
  // after that the sequence is fixed.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_ADD, OP_CMP, OP_AND: state_next = S_RDA;
            OP_MOV, OP_MVN:         state_next = S_RDB;
            OP_MOVI:                state_next = S_EXEC;
            default:                state_next = S_WB;
          endcase
        end
      end
      S_RDA:   state_next = S_RDB;
      S_RDB:   state_next = S_EXEC;
      S_EXEC:  state_next = S_WB;
      S_WB:    state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Moore outputs; ready also drops combinationally while reset is held.
  always_comb begin
    cmd_ready = reset_n && (state_reg == S_IDLE);
    done      = (state_reg == S_WB);
  end

  // Shifter and ALU
  always_comb begin
    case (shift_reg)
      2'b01:   b_shifted = {b_reg[WIDTH-2:0], 1'b0};
      2'b10:   b_shifted = {1'b0, b_reg[WIDTH-1:1]};
      2'b11:   b_shifted = {b_reg[WIDTH-1], b_reg[WIDTH-1:1]};
      default: b_shifted = b_reg;
    endcase
    // MOV/MVN never load A, so force the unused operand to zero.
    a_in    = (op_reg == OP_MOV || op_reg == OP_MVN) ? '0 : a_reg;
    sum     = a_in + b_shifted;
    diff    = a_in - b_shifted;
    alu_out = '0;
    alu_v   = 1'b0;
    case (op_reg)
      OP_MOVI: alu_out = imm_reg;
      OP_MOV:  alu_out = b_shifted;
      OP_ADD: begin
        alu_out = sum;
        alu_v   = (a_in[WIDTH-1] == b_shifted[WIDTH-1]) && (sum[WIDTH-1] != a_in[WIDTH-1]);
      end
      OP_CMP: begin
        alu_out = diff;
        alu_v   = (a_in[WIDTH-1] != b_shifted[WIDTH-1]) && (diff[WIDTH-1] != a_in[WIDTH-1]);
      end
      OP_AND:  alu_out = a_in & b_shifted;
      OP_MVN:  alu_out = ~b_shifted;
      default: alu_out = '0;
    endcase
  end

  assign write_en = (op_reg <= OP_MVN) && (op_reg != OP_CMP);

  // Datapath registers. The register file is cleared by reset, so it is a
  // flop array rather than block RAM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_reg     <= '0;
      shift_reg  <= '0;
      rd_reg     <= '0;
      rn_reg     <= '0;
      rm_reg     <= '0;
      imm_reg    <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      c_reg      <= '0;
      status_reg <= '0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (accept) begin
            op_reg    <= cmd_op;
            shift_reg <= cmd_shift;
            rd_reg    <= cmd_rd;
            rn_reg    <= cmd_rn;
            rm_reg    <= cmd_rm;
            imm_reg   <= cmd_imm;
          end
        end
        S_RDA:  a_reg <= regs[rn_reg];
        S_RDB:  b_reg <= regs[rm_reg];
        S_EXEC: begin
          c_reg      <= alu_out;
          status_reg <= {alu_out[WIDTH-1], alu_v, (alu_out == '0)};
        end
        S_WB: begin
          if (write_en) regs[rd_reg] <= c_reg;
        end
        default: ;
      endcase
    end
  end

  assign result   = c_reg;
  assign status   = status_reg;
  assign dbg_data = regs[dbg_addr];

endmodule

// File: tb/tb_seq_datapath.sv
// Scoreboard bench for seq_datapath: commands are scored against an
// arithmetic model at acceptance time; a monitor checks each done pulse.
module tb_seq_datapath;
  localparam int W  = 16;
  localparam int NR = 8;
  localparam int RW = $clog2(NR);

  logic          clk, reset_n, cmd_valid, cmd_ready, done;
  logic [2:0]    cmd_op, status;
  logic [1:0]    cmd_shift;
  logic [RW-1:0] cmd_rd, cmd_rn, cmd_rm, dbg_addr, dbg_addr_stim, dbg_addr_mon;
  logic [W-1:0]  cmd_imm, result, dbg_data;
  logic          stim_mode, mon_busy;

  assign dbg_addr = stim_mode ? dbg_addr_stim : dbg_addr_mon;

  seq_datapath #(.WIDTH(W), .NREGS(NR)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_shift(cmd_shift), .cmd_rd(cmd_rd), .cmd_rn(cmd_rn),
    .cmd_rm(cmd_rm), .cmd_imm(cmd_imm), .done(done), .result(result),
    .status(status), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] res;
    logic [2:0]   st;
    int           rd;
    logic [W-1:0] rdv;
    int           lat;
    int           acc;
  } exp_t;

  exp_t         q[$];
  logic [W-1:0] mr [NR];
  logic [W-1:0] mc;
  logic [2:0]   mst;
  int           n_tests = 0;
  int           n_fail = 0;
  int           cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: sequential command semantics with plain integer math.
  task automatic model_accept();
    longint m = longint'(1) << W;
    longint h = longint'(1) << (W - 1);
    longint a, b, r, sa, sb, s;
    logic   v;
    exp_t   e;
    a = longint'(mr[cmd_rn]);
    b = longint'(mr[cmd_rm]);
    case (cmd_shift)
      2'd1: b = (b * 2) % m;
      2'd2: b = b / 2;
      2'd3: b = b / 2 + ((b >= h) ? h : 0);
      default: ;
    endcase
    sa = (a >= h) ? a - m : a;
    sb = (b >= h) ? b - m : b;
    v = 1'b0;
    r = 0;
    e.op = cmd_op;
    e.rd = int'(cmd_rd);
    case (cmd_op)
      3'd0: begin r = longint'(cmd_imm); e.lat = 1; end
      3'd1: begin r = b; e.lat = 2; end
      3'd2: begin r = (a + b) % m; s = sa + sb; v = (s > h - 1) || (s < -h); e.lat = 3; end
      3'd3: begin r = (a - b + m) % m; s = sa - sb; v = (s > h - 1) || (s < -h); e.lat = 3; end
      3'd4: begin r = a & b; e.lat = 3; end
      3'd5: begin r = m - 1 - b; e.lat = 2; end
      default: e.lat = 0;
    endcase
    if (cmd_op <= 3'd5) begin
      mc  = r[W-1:0];
      mst = {mc[W-1], v, (r == 0)};
      if (cmd_op != 3'd3) mr[cmd_rd] = mc;
    end
    e.res = mc;
    e.st  = mst;
    e.rdv = mr[cmd_rd];
    e.acc = cyc + 1;
    q.push_back(e);
  endtask

  task automatic model_clear();
    for (int i = 0; i < NR; i++) mr[i] = '0;
    mc  = '0;
    mst = '0;
    q.delete();
  endtask

  // Monitor: pops one expectation per done pulse.
  initial begin
    mon_busy = 1'b0;
    dbg_addr_mon = '0;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1 && done === 1'b1) begin
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1 expected no command in flight");
        end else begin
          exp_t e;
          e = q.pop_front();
          mon_busy = 1'b1;
          $display("[TB] done op=%0d rd=%0d result=%h status=%b lat=%0d", e.op, e.rd, result, status, cyc - e.acc);
          chk("result", result, e.res);
          chk("status", status, e.st);
          chk("latency", cyc - e.acc, e.lat);
          dbg_addr_mon = e.rd[RW-1:0];
          @(negedge clk);
          chk("done_pulse", done, 1'b0);
          chk("rd_writeback", dbg_data, e.rdv);
          mon_busy = 1'b0;
        end
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [1:0] sh, input int rd, input int rn,
                       input int rm, input logic [W-1:0] imm);
    bit ok = 0;
    int busy = 0;
    int lat;
    @(negedge clk);
    cmd_op = op; cmd_shift = sh; cmd_imm = imm;
    cmd_rd = rd[RW-1:0]; cmd_rn = rn[RW-1:0]; cmd_rm = rm[RW-1:0];
    cmd_valid = 1'b1;
    for (int t = 0; t < 40 && !ok; t++) begin
      if (cmd_ready) begin
        model_accept();
        lat = q[q.size()-1].lat;
        ok = 1;
      end else @(negedge clk);
    end
    if (!ok) begin
      chk("accept_timeout", 0, 1);
      lat = 0;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int t = 0; t < 20 && !cmd_ready; t++) begin
      busy++;
      @(negedge clk);
    end
    chk("busy_cycles", busy, lat + 1);
  endtask

  task automatic drain();
    bit ok = 0;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      if (q.size() == 0 && !mon_busy && cmd_ready) ok = 1;
    end
    if (!ok) chk("drain_timeout", 0, 1);
  endtask

  task automatic check_reg(input int idx, input logic [W-1:0] exp);
    stim_mode = 1'b1;
    dbg_addr_stim = idx[RW-1:0];
    #1;
    chk($sformatf("reg%0d", idx), dbg_data, exp);
    stim_mode = 1'b0;
  endtask

  task automatic check_all_regs();
    for (int i = 0; i < NR; i++) check_reg(i, mr[i]);
  endtask

  task automatic reset_checks();
    chk("rst_ready", cmd_ready, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_result", result, '0);
    chk("rst_status", status, 3'b000);
    for (int i = 0; i < NR; i++) check_reg(i, '0);
  endtask

  initial begin
    reset_n = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_shift = '0;
    cmd_rd = '0; cmd_rn = '0; cmd_rm = '0; cmd_imm = '0;
    stim_mode = 1'b0; dbg_addr_stim = '0;
    model_clear();

    // Asynchronous reset pulse in the middle of a cycle
    #12 reset_n = 1'b0;
    #1 reset_checks();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", cmd_ready, 1'b1);

    // ADD sequence
    issue(3'd0, 2'd0, 1, 0, 0, 16'h0007);
    issue(3'd0, 2'd0, 2, 0, 0, 16'h0002);
    issue(3'd2, 2'd1, 3, 1, 2, 16'h0000);
    drain();
    check_reg(3, 16'h000B);
    chk("add_status", status, 3'b000);

    // CMP overflow
    issue(3'd0, 2'd0, 4, 0, 0, 16'h7FFF);
    issue(3'd0, 2'd0, 5, 0, 0, 16'hFFFF);
    issue(3'd3, 2'd0, 0, 4, 5, 16'h0000);
    drain();
    chk("cmp_result", result, 16'h8000);
    chk("cmp_status", status, 3'b110);
    check_reg(0, 16'h0000);
    check_reg(4, 16'h7FFF);
    check_reg(5, 16'hFFFF);

    // Shift / logic
    issue(3'd0, 2'd0, 6, 0, 0, 16'h8000);
    issue(3'd5, 2'd3, 7, 0, 6, 16'h0000);
    drain();
    check_reg(7, 16'h3FFF);
    chk("mvn_status", status, 3'b000);
    issue(3'd4, 2'd0, 0, 7, 0, 16'h0000);
    drain();
    chk("and_status", status, 3'b001);

    // NOP, then rd == rn == rm
    issue(3'd7, 2'd2, 2, 1, 1, 16'hABCD);
    issue(3'd0, 2'd0, 1, 0, 0, 16'h0003);
    issue(3'd2, 2'd0, 1, 1, 1, 16'h0000);
    drain();
    check_reg(1, 16'h0006);
    check_all_regs();

    // Random traffic, cmd_valid mostly held high with changing fields
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      cmd_op    = 3'($urandom_range(0, 7));
      cmd_shift = 2'($urandom_range(0, 3));
      cmd_rd    = RW'($urandom_range(0, NR - 1));
      cmd_rn    = RW'($urandom_range(0, NR - 1));
      cmd_rm    = RW'($urandom_range(0, NR - 1));
      case ($urandom_range(0, 4))
        0: cmd_imm = '0;
        1: cmd_imm = {1'b0, {(W-1){1'b1}}};
        2: cmd_imm = {W{1'b1}};
        3: cmd_imm = {1'b1, {(W-1){1'b0}}};
        default: cmd_imm = W'($urandom);
      endcase
      cmd_valid = ($urandom_range(0, 7) != 0);
      if (cmd_valid && cmd_ready) model_accept();
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    drain();
    check_all_regs();

    // Reset during EXEC of ADD R3 = R1 + R2: no done, everything cleared
    @(negedge clk);
    cmd_op = 3'd2; cmd_shift = 2'd0; cmd_rd = RW'(3); cmd_rn = RW'(1); cmd_rm = RW'(2);
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 reset_n = 1'b0;
    model_clear();
    #1 reset_checks();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("ready_after_abort", cmd_ready, 1'b1);
    repeat (8) @(negedge clk);

    issue(3'd0, 2'd0, 2, 0, 0, 16'h1234);
    drain();
    check_all_regs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
